// File: rtl/crack_if.sv
// crack_if: start/stop handshake, result, ARC4 engine and plaintext RAM signals
// of the key-search controller.
interface crack_if #(parameter int KEY_W = 24);
    logic             en;
    logic             rdy;
    logic             abort;
    logic [KEY_W-1:0] key;
    logic             key_valid;
    logic             exhausted;
    logic             a4_en;
    logic             a4_rdy;
    logic [7:0]       pt_addr;
    logic [7:0]       pt_rddata;
    modport master (output en, abort, a4_rdy, pt_rddata,
                    input  rdy, key, key_valid, exhausted, a4_en, pt_addr);
    modport slave  (input  en, abort, a4_rdy, pt_rddata,
                    output rdy, key, key_valid, exhausted, a4_en, pt_addr);
endinterface

// File: rtl/crack_ctrl.sv
// crack_ctrl: walks the key space, runs ARC4 per key and accepts the first key
// whose length-prefixed plaintext is entirely printable.
module crack_ctrl #(
    parameter int         KEY_W     = 24,
    parameter int         KEY_START = 0,
    parameter int         KEY_STEP  = 1,
    parameter logic [7:0] PT_LO     = 8'h20,
    parameter logic [7:0] PT_HI     = 8'h7E
) (
    input logic    clk,
    input logic    rst,
    crack_if.slave bus
);
    typedef enum logic [2:0] {IDLE, START, ARC4, RDLEN_A, RDLEN_B, RDP_A, RDP_B, INCR} state_t;

    localparam logic [KEY_W-1:0] START_K = KEY_W'(KEY_START);

    state_t           r_state;
    logic [KEY_W-1:0] r_key;
    logic             r_key_valid;
    logic             r_exhausted;
    logic             r_a4_en;
    logic             r_abort;
    logic [7:0]       r_pt_addr;
    logic [7:0]       r_len;
    logic [KEY_W:0]   w_sum;
    logic             w_pass;

    // the byte index i is kept in r_pt_addr itself
    assign w_sum         = {1'b0, r_key} + (KEY_W+1)'(KEY_STEP);
    assign w_pass        = (bus.pt_rddata >= PT_LO) && (bus.pt_rddata <= PT_HI);
    assign bus.rdy       = (r_state == IDLE);
    assign bus.key       = r_key;
    assign bus.key_valid = r_key_valid;
    assign bus.exhausted = r_exhausted;
    assign bus.a4_en     = r_a4_en;
    assign bus.pt_addr   = r_pt_addr;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_key       <= START_K;
            r_key_valid <= 1'b0;
            r_exhausted <= 1'b0;
            r_a4_en     <= 1'b0;
            r_abort     <= 1'b0;
            r_pt_addr   <= 8'd0;
            r_len       <= 8'd0;
        end else begin
            r_a4_en <= 1'b0;
            unique case (r_state)
                IDLE: if (bus.en) begin
                    r_key       <= START_K;
                    r_key_valid <= 1'b0;
                    r_exhausted <= 1'b0;
                    r_abort     <= 1'b0;
                    r_state     <= START;
                end
                START: if (bus.abort) r_state <= IDLE;
                       else if (bus.a4_rdy) begin
                           r_a4_en <= 1'b1;
                           r_state <= ARC4;
                       end
                // r_a4_en is still high in the first ARC4 cycle, masking a stale a4_rdy
                ARC4: begin
                    r_abort <= r_abort | bus.abort;
                    if (!r_a4_en && bus.a4_rdy) begin
                        r_pt_addr <= 8'd0;
                        r_state   <= (r_abort || bus.abort) ? IDLE : RDLEN_A;
                    end
                end
                RDLEN_A: r_state <= bus.abort ? IDLE : RDLEN_B;
                RDLEN_B: if (bus.abort) r_state <= IDLE;
                         else if (bus.pt_rddata == 8'd0) begin
                             r_key_valid <= 1'b1;
                             r_state     <= IDLE;
                         end else begin
                             r_len     <= bus.pt_rddata;
                             r_pt_addr <= 8'd1;
                             r_state   <= RDP_A;
                         end
                RDP_A: r_state <= bus.abort ? IDLE : RDP_B;
                RDP_B: if (bus.abort) r_state <= IDLE;
                       else if (!w_pass) r_state <= INCR;
                       else if (r_pt_addr == r_len) begin
                           r_key_valid <= 1'b1;
                           r_state     <= IDLE;
                       end else begin
                           r_pt_addr <= r_pt_addr + 8'd1;
                           r_state   <= RDP_A;
                       end
                INCR: if (bus.abort) r_state <= IDLE;
                      else if (w_sum[KEY_W]) begin
                          r_exhausted <= 1'b1;
                          r_state     <= IDLE;
                      end else begin
                          r_key   <= w_sum[KEY_W-1:0];
                          r_state <= START;
                      end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_crack_ctrl.sv
// tb_crack_ctrl: drives two controllers (default and 4-bit/step-2) against an
// ARC4 latency model and a plaintext table, checking results and RAM read order.
module tb_crack_ctrl;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    int         checks = 0;
    int         errors = 0;
    int         n_pulse = 0;
    int         n_pulse4 = 0;
    int         a4_cnt = 0;
    int         b4_cnt = 0;
    logic [7:0] mem [16][8];
    logic [7:0] obs_q[$];
    logic [7:0] exp_q[$];

    crack_if #(.KEY_W(24)) a ();
    crack_if #(.KEY_W(4))  b ();

    crack_ctrl u_dut (.clk(clk), .rst(rst), .bus(a.slave));
    crack_ctrl #(.KEY_W(4), .KEY_START(1), .KEY_STEP(2)) u_dut4 (.clk(clk), .rst(rst), .bus(b.slave));

    always #5 clk = ~clk;

    function automatic logic [7:0] ram(int k, int adr);
        if (k < 16 && adr < 8) return mem[k][adr];
        return (adr == 0) ? 8'd1 : 8'd0;
    endfunction

    // ARC4 engines with random latency, synchronous plaintext RAMs
    always @(posedge clk) begin
        a.pt_rddata <= ram(int'(a.key), int'(a.pt_addr));
        b.pt_rddata <= 8'h05;
        if (rst) begin
            a.a4_rdy <= 1'b1; a4_cnt <= 0;
            b.a4_rdy <= 1'b1; b4_cnt <= 0;
        end else begin
            if (a.a4_en) begin a.a4_rdy <= 1'b0; a4_cnt <= $urandom_range(1, 4); end
            else if (a4_cnt > 0) begin a4_cnt <= a4_cnt - 1; if (a4_cnt == 1) a.a4_rdy <= 1'b1; end
            if (b.a4_en) begin b.a4_rdy <= 1'b0; b4_cnt <= $urandom_range(1, 4); end
            else if (b4_cnt > 0) begin b4_cnt <= b4_cnt - 1; if (b4_cnt == 1) b.a4_rdy <= 1'b1; end
        end
    end

    always @(negedge clk) begin
        if (a.a4_en) n_pulse++;
        if (b.a4_en) n_pulse4++;
        if (obs_q.size() > 0 && a.pt_addr != obs_q[$]) obs_q.push_back(a.pt_addr);
    end

    // Reference: first key 0..15 whose plaintext is all printable, plus the
    // distinct-consecutive sequence of addresses a correct search must issue.
    function automatic int model_a();
        exp_q = {8'h00};
        for (int k = 0; k < 16; k++) begin
            int len = int'(ram(k, 0));
            bit ok = 1'b1;
            if (exp_q[$] != 8'h00) exp_q.push_back(8'h00);
            for (int i = 1; i <= len && ok; i++) begin
                exp_q.push_back(8'(i));
                if (!(ram(k, i) inside {[8'h20:8'h7E]})) ok = 1'b0;
            end
            if (ok) return k;
        end
        return -1;
    endfunction

    task automatic set_pt(input int k, input logic [7:0] l, input logic [7:0] p1 = 0, p2 = 0, p3 = 0, p4 = 0, p5 = 0);
        mem[k][0] = l; mem[k][1] = p1; mem[k][2] = p2; mem[k][3] = p3; mem[k][4] = p4; mem[k][5] = p5;
    endtask

    task automatic clear_mem();
        for (int k = 0; k < 16; k++) for (int j = 0; j < 8; j++) mem[k][j] = (j == 0) ? 8'd1 : 8'd0;
    endtask

    task automatic do_reset();
        rst = 1'b1; a.en = 1'b0; a.abort = 1'b0; b.en = 1'b0; b.abort = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        obs_q = {8'h00};
        n_pulse = 0;
        n_pulse4 = 0;
    endtask

    task automatic start_a();
        a.en = 1'b1;
        @(negedge clk);
        a.en = 1'b0;
    endtask

    task automatic test_reset();
        int cyc;
        clear_mem();
        do_reset();
        checks += 6;
        if (a.rdy !== 1'b1)       begin errors++; $display("FAIL reset rdy: got %b want 1", a.rdy); end
        if (a.key !== 24'd0)      begin errors++; $display("FAIL reset key: got %h want 0", a.key); end
        if (a.key_valid !== 1'b0) begin errors++; $display("FAIL reset key_valid: got %b want 0", a.key_valid); end
        if (a.exhausted !== 1'b0) begin errors++; $display("FAIL reset exhausted: got %b want 0", a.exhausted); end
        if (a.a4_en !== 1'b0)     begin errors++; $display("FAIL reset a4_en: got %b want 0", a.a4_en); end
        if (a.pt_addr !== 8'd0)   begin errors++; $display("FAIL reset pt_addr: got %h want 0", a.pt_addr); end
        set_pt(0, 5, 8'h41, 8'h41, 8'h41, 8'h41, 8'h41);
        start_a();
        for (cyc = 0; cyc < 100 && a.pt_addr !== 8'd1; cyc++) @(negedge clk);
        checks++;
        if (a.pt_addr !== 8'd1) begin errors++; $display("FAIL reset_rdp reach: pt_addr %h want 01", a.pt_addr); end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks += 5;
        if (a.rdy !== 1'b1)       begin errors++; $display("FAIL reset_rdp rdy: got %b want 1", a.rdy); end
        if (a.key !== 24'd0)      begin errors++; $display("FAIL reset_rdp key: got %h want 0", a.key); end
        if (a.key_valid !== 1'b0) begin errors++; $display("FAIL reset_rdp key_valid: got %b want 0", a.key_valid); end
        if (a.exhausted !== 1'b0) begin errors++; $display("FAIL reset_rdp exhausted: got %b want 0", a.exhausted); end
        if (a.pt_addr !== 8'd0)   begin errors++; $display("FAIL reset_rdp pt_addr: got %h want 0", a.pt_addr); end
        @(negedge clk);
        rst = 1'b0;
        n_pulse = 0;
        repeat (10) @(negedge clk);
        checks += 2;
        if (n_pulse != 0)   begin errors++; $display("FAIL reset_rdp a4_en after rst: got %0d pulses want 0", n_pulse); end
        if (a.rdy !== 1'b1) begin errors++; $display("FAIL reset_rdp stays idle: rdy %b want 1", a.rdy); end
    endtask

    // mode 0: two-key example, 1: boundary pass, 2: boundary fails, 3: random table
    task automatic test_search(input int mode);
        int  ek;
        int  cyc;
        bit  same;
        clear_mem();
        if (mode == 0) begin
            set_pt(0, 2, 8'h41, 8'h1F);
            set_pt(1, 2, 8'h48, 8'h49);
        end else if (mode == 1) begin
            set_pt(0, 2, 8'h20, 8'h7E);
        end else if (mode == 2) begin
            set_pt(0, 1, 8'h1F);
            set_pt(1, 1, 8'h7F);
            set_pt(2, 5, 8'h10, 8'h41, 8'h41, 8'h41, 8'h41);
            set_pt(3, 2, 8'h7E, 8'h20);
        end else begin
            for (int k = 0; k < 16; k++) begin
                mem[k][0] = 8'($urandom_range(0, 7));
                for (int j = 1; j < 8; j++) begin
                    int r = $urandom_range(0, 19);
                    mem[k][j] = (r == 0) ? 8'h1F : (r == 1) ? 8'h7F : (r == 2) ? 8'h20 : (r == 3) ? 8'h7E :
                                (r == 4) ? 8'($urandom_range(128, 255)) : 8'($urandom_range(33, 125));
                end
            end
            if (model_a() < 0) mem[15][0] = 8'd0;
        end
        ek = model_a();
        do_reset();
        start_a();
        for (cyc = 0; cyc < 3000 && a.rdy !== 1'b1; cyc++) begin
            a.en = (cyc == 2);
            @(negedge clk);
        end
        a.en = 1'b0;
        same = (obs_q.size() == exp_q.size());
        foreach (exp_q[j]) if (same && obs_q[j] !== exp_q[j]) same = 1'b0;
        checks += 6;
        if (a.rdy !== 1'b1)         begin errors++; $display("FAIL search%0d done: rdy %b want 1", mode, a.rdy); end
        if (a.key !== 24'(ek))      begin errors++; $display("FAIL search%0d key: got %h want %h", mode, a.key, 24'(ek)); end
        if (a.key_valid !== 1'b1)   begin errors++; $display("FAIL search%0d key_valid: got %b want 1", mode, a.key_valid); end
        if (a.exhausted !== 1'b0)   begin errors++; $display("FAIL search%0d exhausted: got %b want 0", mode, a.exhausted); end
        if (n_pulse != ek + 1)      begin errors++; $display("FAIL search%0d a4_en pulses: got %0d want %0d", mode, n_pulse, ek + 1); end
        if (!same)                  begin errors++; $display("FAIL search%0d address order: got %0d changes want %0d", mode, obs_q.size(), exp_q.size()); end
    endtask

    task automatic test_len0();
        int cyc;
        clear_mem();
        set_pt(0, 0);
        do_reset();
        start_a();
        for (cyc = 0; cyc < 200 && a.rdy !== 1'b1; cyc++) @(negedge clk);
        checks += 3;
        if (a.key !== 24'd0)      begin errors++; $display("FAIL len0 key: got %h want 0", a.key); end
        if (a.key_valid !== 1'b1) begin errors++; $display("FAIL len0 key_valid: got %b want 1", a.key_valid); end
        if (n_pulse != 1)         begin errors++; $display("FAIL len0 a4_en pulses: got %0d want 1", n_pulse); end
    endtask

    task automatic test_abort_arc4();
        int cyc;
        clear_mem();
        set_pt(0, 0);
        do_reset();
        start_a();
        for (cyc = 0; cyc < 50 && a.a4_en !== 1'b1; cyc++) @(negedge clk);
        a.abort = 1'b1;
        @(negedge clk);
        a.abort = 1'b0;
        for (cyc = 0; cyc < 50 && a.a4_rdy !== 1'b1; cyc++) @(negedge clk);
        checks++;
        if (a.rdy !== 1'b0) begin errors++; $display("FAIL abort_arc4 early idle: rdy %b want 0", a.rdy); end
        @(negedge clk);
        checks += 5;
        if (a.rdy !== 1'b1)       begin errors++; $display("FAIL abort_arc4 idle: rdy %b want 1", a.rdy); end
        if (a.key_valid !== 1'b0) begin errors++; $display("FAIL abort_arc4 key_valid: got %b want 0", a.key_valid); end
        if (a.exhausted !== 1'b0) begin errors++; $display("FAIL abort_arc4 exhausted: got %b want 0", a.exhausted); end
        if (obs_q.size() != 1)    begin errors++; $display("FAIL abort_arc4 ram reads: got %0d addr changes want 0", obs_q.size() - 1); end
        if (n_pulse != 1)         begin errors++; $display("FAIL abort_arc4 a4_en pulses: got %0d want 1", n_pulse); end
    endtask

    task automatic test_abort_rdp();
        int cyc;
        clear_mem();
        set_pt(0, 5, 8'h41, 8'h42, 8'h43, 8'h44, 8'h45);
        do_reset();
        start_a();
        for (cyc = 0; cyc < 100 && a.pt_addr !== 8'd2; cyc++) @(negedge clk);
        a.abort = 1'b1;
        @(negedge clk);
        a.abort = 1'b0;
        checks += 3;
        if (a.rdy !== 1'b1)       begin errors++; $display("FAIL abort_rdp idle: rdy %b want 1", a.rdy); end
        if (a.key_valid !== 1'b0) begin errors++; $display("FAIL abort_rdp key_valid: got %b want 0", a.key_valid); end
        if (a.exhausted !== 1'b0) begin errors++; $display("FAIL abort_rdp exhausted: got %b want 0", a.exhausted); end
    endtask

    task automatic test_en_abort_idle();
        int cyc;
        clear_mem();
        set_pt(0, 1, 8'h41);
        do_reset();
        a.en = 1'b1;
        a.abort = 1'b1;
        @(negedge clk);
        a.en = 1'b0;
        a.abort = 1'b0;
        checks++;
        if (a.rdy !== 1'b0) begin errors++; $display("FAIL en_abort start: rdy %b want 0", a.rdy); end
        for (cyc = 0; cyc < 200 && a.rdy !== 1'b1; cyc++) @(negedge clk);
        checks++;
        if (a.key_valid !== 1'b1) begin errors++; $display("FAIL en_abort key_valid: got %b want 1", a.key_valid); end
    endtask

    task automatic test_exhaust();
        int cyc;
        int ecount = 0;
        int elast = 0;
        for (int k = 1; k < 16; k += 2) begin ecount++; elast = k; end
        do_reset();
        b.en = 1'b1;
        @(negedge clk);
        b.en = 1'b0;
        for (cyc = 0; cyc < 2000 && b.rdy !== 1'b1; cyc++) @(negedge clk);
        checks += 5;
        if (b.rdy !== 1'b1)       begin errors++; $display("FAIL exhaust done: rdy %b want 1", b.rdy); end
        if (b.exhausted !== 1'b1) begin errors++; $display("FAIL exhaust flag: got %b want 1", b.exhausted); end
        if (b.key_valid !== 1'b0) begin errors++; $display("FAIL exhaust key_valid: got %b want 0", b.key_valid); end
        if (b.key !== 4'(elast))  begin errors++; $display("FAIL exhaust key: got %h want %h", b.key, 4'(elast)); end
        if (n_pulse4 != ecount)   begin errors++; $display("FAIL exhaust a4_en pulses: got %0d want %0d", n_pulse4, ecount); end
    endtask

    initial begin
        a.en = 1'b0; a.abort = 1'b0; b.en = 1'b0; b.abort = 1'b0;
        test_reset();
        test_search(0);
        test_search(1);
        test_search(2);
        for (int n = 0; n < 20; n++) test_search(3);
        test_len0();
        test_abort_arc4();
        test_abort_rdp();
        test_en_abort_idle();
        test_exhaust();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/crack_ctrl.md
CRACK_CTRL -- requirements
Module: crack_ctrl

Interface
REQ-001 Parameter KEY_W, default 24: key width in bits.
REQ-002 Parameter KEY_START, default 0: first key tried after each start.
REQ-003 Parameter KEY_STEP, default 1: key increment; lets N cores split the key space using KEY_START=core id, KEY_STEP=N.
REQ-004 Parameter PT_LO, default 8'h20: lowest accepted plaintext byte.
REQ-005 Parameter PT_HI, default 8'h7E: highest accepted plaintext byte.
REQ-006 clk  in  1  single clock; all logic on its rising edge.
REQ-007 rst  in  1  reset; synchronous, active-high.
REQ-008 en  in  1  start request; accepted only in IDLE.
REQ-009 rdy  out  1  high only in IDLE; block ready for en.
REQ-010 abort  in  1  stop request, e.g. a sibling core found the key.
REQ-011 key  out  KEY_W  current or found key; also drives the ARC4 engine key.
REQ-012 key_valid  out  1  high in IDLE after a successful search.
REQ-013 exhausted  out  1  high in IDLE after the whole key space failed.
REQ-014 a4_en  out  1  one-cycle start pulse to the ARC4 engine.
REQ-015 a4_rdy  in  1  ARC4 engine idle/done.
REQ-016 pt_addr  out  8  plaintext RAM read address.
REQ-017 pt_rddata  in  8  plaintext RAM data, valid one cycle after pt_addr.

Function
REQ-018 The block SHALL implement states IDLE, START, ARC4, RDLEN_A, RDLEN_B, RDP_A, RDP_B, INCR.
REQ-019 IDLE: on en=1, the block SHALL load key=KEY_START, clear key_valid and exhausted, and go to START.
REQ-020 START: when a4_rdy=1, the block SHALL pulse a4_en for exactly one cycle and go to ARC4; otherwise it stays in START.
REQ-021 ARC4: the block SHALL ignore a4_rdy in the first cycle after a4_en, then go to RDLEN_A when a4_rdy=1.
REQ-022 RDLEN_A: drive pt_addr=0. RDLEN_B: capture len=pt_rddata and set index i=1.
REQ-023 If len=0, the block SHALL treat the key as valid: set key_valid=1 and return to IDLE.
REQ-024 RDP_A: drive pt_addr=i. RDP_B: test the byte with the unsigned comparison PT_LO <= pt_rddata <= PT_HI.
REQ-025 On a failing byte, the block SHALL go straight to INCR; no further bytes are read for that key.
REQ-026 On a passing byte with i=len, the block SHALL set key_valid=1, hold key, and go to IDLE.
REQ-027 On a passing byte with i<len, the block SHALL increment i and go to RDP_A.
REQ-028 INCR: the block SHALL compute key+KEY_STEP at KEY_W+1 bits.
REQ-029 If that sum carries out of KEY_W bits, the block SHALL set exhausted=1, hold the last tried key, and go to IDLE.
REQ-030 If there is no carry, the block SHALL update key and go to START.
REQ-031 abort=1 in START, RDLEN_*, RDP_* or INCR SHALL send the block to IDLE next cycle with key_valid=0 and exhausted=0.
REQ-032 abort=1 in ARC4 SHALL be latched; the block waits for a4_rdy=1, then goes to IDLE without reading RAM.
REQ-033 The block SHALL never assert a4_en outside START.
REQ-034 rdy SHALL be combinational from state (rdy = state is IDLE).
REQ-035 en outside IDLE SHALL be ignored.
REQ-036 If en and abort are both high in IDLE, en wins and abort is ignored.
REQ-037 Per-key cost after a4_rdy returns SHALL be 2 cycles for the length read, plus 2 cycles per byte examined, plus 1 cycle in INCR.

Reset
REQ-038 While rst=1, the block SHALL force: state=IDLE, rdy=1, key=KEY_START, key_valid=0, exhausted=0, a4_en=0, pt_addr=0, abort latch cleared.
REQ-039 rst SHALL take priority over all other inputs in every state, including mid-ARC4. After rst the block SHALL not issue a4_en until a new en.

Verification
REQ-040 Reset: rst=1 for 2 cycles during RDP_B -> next cycle IDLE, rdy=1, key_valid=0, exhausted=0, key=0.
REQ-041 Defaults, RAM model: key 0 gives pt={2,8'h41,8'h1F}, key 1 gives pt={2,8'h48,8'h49} -> key=24'h000001, key_valid=1, rdy=1, exactly 2 a4_en pulses.
REQ-042 Boundaries: bytes 8'h20 and 8'h7E pass; 8'h1F and 8'h7F fail. A fail at pt[1] with len=5 -> no pt_addr 2..5 is issued for that key.
REQ-043 KEY_W=4, KEY_START=1, KEY_STEP=2, all keys fail -> keys 1,3,...,15 tried (8 a4_en pulses), then exhausted=1, key=4'hF, key_valid=0.
REQ-044 abort pulse in ARC4 -> no RAM read; IDLE on the cycle after a4_rdy rises; key_valid=0, exhausted=0.
REQ-045 len=0 for key KEY_START -> key_valid=1 with key=KEY_START after a single ARC4 run.
